// File: rtl/fib_arbiter.sv
// fib_arbiter
//
// Shares one Fibonacci compute unit among NREQ requesters. Requests are
// granted round-robin. The granted operand is handed to the unit through its
// A/IEA/OE handshake, and the unit's result is returned to the granted
// requester together with a one-hot completion pulse. The unit has no reset of
// its own, so after reset (and after a watchdog timeout) the arbiter sits in
// FLUSH long enough for any calculation already in flight to finish and drop
// its OE.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   REQ      in   [NREQ]       per-requester request level, held until ACK
//   REQ_A    in   [NREQ*NW]    operands, requester i at [i*NW +: NW]
//   ACK      out  [NREQ]       one-hot pulse: request accepted, operand latched
//   DONE     out  [NREQ]       one-hot pulse: RES_Y valid for that requester
//   RES_Y    out  [BITS]       last captured result, held between DONEs
//   BUSY     out              high whenever the state is not IDLE
//   TIMEOUT  out              sticky watchdog flag, cleared only by RST
//   FIB_A    out  [BITS]       operand to the unit
//   FIB_IEA  out              input-enable to the unit
//   FIB_Y    in   [BITS]       unit result
//   FIB_OE   in               unit output-valid

module fib_arbiter #(
    parameter int NREQ = 4,
    parameter int NW   = 6,
    parameter int BITS = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*NW-1:0]   REQ_A,
    output logic [NREQ-1:0]      ACK,
    output logic [NREQ-1:0]      DONE,
    output logic [BITS-1:0]      RES_Y,
    output logic                 BUSY,
    output logic                 TIMEOUT,
    output logic [BITS-1:0]      FIB_A,
    output logic                 FIB_IEA,
    input  logic [BITS-1:0]      FIB_Y,
    input  logic                 FIB_OE
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Wide enough to hold 2^NW+8 for any NW.
    localparam int CW = NW + 4;

    // Flush lasts 2^NW+4 cycles: terminal count is the last counter value.
    localparam logic [CW-1:0] FLUSH_LAST = CW'((1 << NW) + 3);

    // Timeout fires on the (2^NW+8)-th WAIT cycle without OE.
    localparam logic [CW-1:0] WDOG_LAST  = CW'((1 << NW) + 7);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic [CW-1:0]   wdog;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cur;

    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [NW-1:0]   grant_op;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin search: the first set REQ bit strictly after the pointer,
    // wrapping modulo NREQ, so the last-served requester has lowest priority.
    always_comb begin : grant_search
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!grant_any && REQ[j]) begin
                grant_any = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

    assign grant_op = REQ_A[grant_idx*NW +: NW];

    // Single FSM with all outputs registered. ACK and DONE are pulses and so
    // default to zero every cycle. FIB_A is only ever loaded in IDLE, where
    // FIB_IEA is already low, so the operand never moves under an active IEA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            wdog      <= '0;
            ptr       <= PW'(NREQ - 1);
            cur       <= '0;
            ACK       <= '0;
            DONE      <= '0;
            RES_Y     <= '0;
            FIB_A     <= '0;
            FIB_IEA   <= 1'b0;
            TIMEOUT   <= 1'b0;
            BUSY      <= 1'b1;
        end else begin
            ACK  <= '0;
            DONE <= '0;
            case (state)
                ST_FLUSH: begin
                    FIB_IEA <= 1'b0;
                    // A unit still holding OE from an abandoned calculation
                    // keeps us here past the nominal count.
                    if (flush_cnt == FLUSH_LAST && !FIB_OE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (flush_cnt != FLUSH_LAST) begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    FIB_IEA <= 1'b0;
                    if (grant_any) begin
                        ACK     <= onehot(grant_idx);
                        FIB_A   <= BITS'(grant_op);
                        FIB_IEA <= 1'b1;
                        cur     <= grant_idx;
                        ptr     <= grant_idx;
                        wdog    <= '0;
                        state   <= ST_WAIT;
                        BUSY    <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (FIB_OE) begin
                        RES_Y   <= FIB_Y;
                        DONE    <= onehot(cur);
                        FIB_IEA <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (wdog == WDOG_LAST) begin
                        // Abandon the request without a DONE; the unit may
                        // still be computing, hence the fresh flush.
                        TIMEOUT   <= 1'b1;
                        FIB_IEA   <= 1'b0;
                        flush_cnt <= '0;
                        state     <= ST_FLUSH;
                    end else begin
                        FIB_IEA <= 1'b1;
                        wdog    <= wdog + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    FIB_IEA <= 1'b0;
                    if (!FIB_OE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    FIB_IEA   <= 1'b0;
                    flush_cnt <= '0;
                    state     <= ST_FLUSH;
                    BUSY      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter
//
// Drives fib_arbiter with NREQ=4, NW=6, BITS=32 against a behavioural
// Fibonacci unit (latency n+3, OE held until IEA drops) that can be switched
// into a stub which never raises OE. Expected ACK/DONE events are queued when
// a request is issued and a monitor pops and compares them as they appear.

module tb_fib_arbiter;

    localparam int NREQ = 4;
    localparam int NW   = 6;
    localparam int BITS = 32;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     REQ;
    logic [NREQ*NW-1:0]  REQ_A;
    logic [NREQ-1:0]     ACK;
    logic [NREQ-1:0]     DONE;
    logic [BITS-1:0]     RES_Y;
    logic                BUSY;
    logic                TIMEOUT;
    logic [BITS-1:0]     FIB_A;
    logic                FIB_IEA;
    logic [BITS-1:0]     FIB_Y  = '0;
    logic                FIB_OE = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic stubUnit = 1'b0;
    logic autoDrop = 1'b1;
    logic outstanding = 1'b0;

    typedef struct packed {
        logic [NREQ-1:0] who;
        logic [BITS-1:0] val;
    } expT;

    expT ackQ[$];
    expT doneQ[$];

    fib_arbiter #(.NREQ(NREQ), .NW(NW), .BITS(BITS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .REQ_A   (REQ_A),
        .ACK     (ACK),
        .DONE    (DONE),
        .RES_Y   (RES_Y),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT),
        .FIB_A   (FIB_A),
        .FIB_IEA (FIB_IEA),
        .FIB_Y   (FIB_Y),
        .FIB_OE  (FIB_OE)
    );

    always #5 CLK = ~CLK;

    // Behavioural Fibonacci unit: no reset, keeps computing if IEA drops.
    logic       uBusy = 1'b0;
    logic [7:0] uCnt  = '0;
    logic [5:0] uN    = '0;

    function automatic logic [31:0] fib32(input int n);
        logic [31:0] a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge CLK) begin
        if (stubUnit) begin
            FIB_OE <= 1'b0;
            uBusy  <= 1'b0;
        end else begin
            if (FIB_OE && !FIB_IEA)
                FIB_OE <= 1'b0;
            if (uBusy) begin
                if (uCnt == 8'd0) begin
                    FIB_OE <= 1'b1;
                    FIB_Y  <= fib32(int'(uN));
                    uBusy  <= 1'b0;
                end else begin
                    uCnt <= uCnt - 8'd1;
                end
            end else if (!FIB_OE && FIB_IEA) begin
                uBusy <= 1'b1;
                uCnt  <= {2'b00, FIB_A[5:0]} + 8'd2;
                uN    <= FIB_A[5:0];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses ACK or DONE.
    always @(negedge CLK) begin : monitor
        expT e;
        if (RST === 1'b1) begin
            outstanding = 1'b0;
        end else begin
            if (BUSY === 1'b0)
                outstanding = 1'b0;
            if (ACK !== '0) begin
                checkOutput("ack_outstanding", 64'(outstanding), 64'd0);
                outstanding = 1'b1;
                if (ackQ.size() == 0) begin
                    checkOutput("ack_unexpected", 64'(ACK), 64'd0);
                end else begin
                    e = ackQ.pop_front();
                    checkOutput("ack_who", 64'(ACK), 64'(e.who));
                    checkOutput("ack_fib_a", 64'(FIB_A), 64'(e.val));
                    checkOutput("ack_iea", 64'(FIB_IEA), 64'd1);
                end
            end
            if (DONE !== '0) begin
                outstanding = 1'b0;
                if (doneQ.size() == 0) begin
                    checkOutput("done_unexpected", 64'(DONE), 64'd0);
                end else begin
                    e = doneQ.pop_front();
                    checkOutput("done_who", 64'(DONE), 64'(e.who));
                    checkOutput("done_res_y", 64'(RES_Y), 64'(e.val));
                    checkOutput("done_iea", 64'(FIB_IEA), 64'd0);
                end
            end
        end
    end

    // Every main-thread cycle goes through here so REQ has a single writer.
    task automatic tick();
        @(negedge CLK);
        if (autoDrop && ACK !== '0)
            REQ = REQ & ~ACK;
    endtask

    task automatic applyStimulus(input int who, input logic [NW-1:0] op, input logic [BITS-1:0] res, input bit expectDone);
        expT e;
        REQ_A[who*NW +: NW] = op;
        REQ[who] = 1'b1;
        e.who = NREQ'(1) << who;
        e.val = BITS'(op);
        ackQ.push_back(e);
        if (expectDone) begin
            e.val = res;
            doneQ.push_back(e);
        end
    endtask

    task automatic measureFlush(input string name);
        int n;
        bit noisy;
        n = 0;
        noisy = 0;
        while (BUSY === 1'b1 && n < 300) begin
            if (ACK !== '0 || DONE !== '0 || FIB_IEA !== 1'b0)
                noisy = 1;
            n++;
            tick();
        end
        checkOutput({name, "_cycles"}, 64'(n), 64'd68);
        checkOutput({name, "_quiet"}, 64'(noisy), 64'd0);
    endtask

    task automatic waitAck(input string name);
        int n;
        n = 0;
        while (ACK === '0 && n < 200) begin
            n++;
            tick();
        end
        checkOutput({name, "_ack_seen"}, 64'(ACK !== '0), 64'd1);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((ackQ.size() != 0 || doneQ.size() != 0 || REQ !== '0 || BUSY !== 1'b0) && n < 2000) begin
            n++;
            tick();
        end
        checkOutput({name, "_drained"}, 64'(n < 2000), 64'd1);
    endtask

    initial begin
        int nAck;
        int cyc;
        int n;

        RST   = 1'b1;
        REQ   = '0;
        REQ_A = '0;

        // Reset
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_ack", 64'(ACK), 64'd0);
        checkOutput("rst_done", 64'(DONE), 64'd0);
        checkOutput("rst_res_y", 64'(RES_Y), 64'd0);
        checkOutput("rst_fib_a", 64'(FIB_A), 64'd0);
        checkOutput("rst_iea", 64'(FIB_IEA), 64'd0);
        checkOutput("rst_timeout", 64'(TIMEOUT), 64'd0);
        checkOutput("rst_busy", 64'(BUSY), 64'd1);
        RST = 1'b0;
        measureFlush("rst_flush");
        checkOutput("rst_flush_res_y", 64'(RES_Y), 64'd0);
        checkOutput("rst_flush_fib_a", 64'(FIB_A), 64'd0);
        checkOutput("rst_flush_timeout", 64'(TIMEOUT), 64'd0);

        // Round robin with all requests held: 0,1,2,3,0
        $display("[TB] round robin");
        autoDrop = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(i, 6'd0, 32'd0, 1);
        applyStimulus(0, 6'd0, 32'd0, 1);
        nAck = 0;
        cyc  = 0;
        while (nAck < 5 && cyc < 1000) begin
            tick();
            cyc++;
            if (ACK !== '0)
                nAck++;
        end
        REQ = '0;
        autoDrop = 1'b1;
        checkOutput("rr_ack_count", 64'(nAck), 64'd5);
        waitDrain("rr");

        // Single request on requester 2, operand 1
        $display("[TB] single request");
        applyStimulus(2, 6'd1, 32'd1, 1);
        waitDrain("single");
        checkOutput("single_busy", 64'(BUSY), 64'd0);

        // Requesters 1 and 3 together, pointer at 2: 3 wins, then 1
        $display("[TB] two requesters");
        applyStimulus(3, 6'd20, 32'd6765, 1);
        applyStimulus(1, 6'd10, 32'd55, 1);
        waitDrain("pair");

        // Widest operand; fib(63) wraps to 32 bits
        $display("[TB] width");
        applyStimulus(0, 6'd63, 32'd3350226146, 1);
        waitDrain("width");
        checkOutput("width_timeout", 64'(TIMEOUT), 64'd0);

        // Watchdog with a stub that never answers
        $display("[TB] watchdog");
        stubUnit = 1'b1;
        applyStimulus(2, 6'd5, 32'd0, 0);
        waitAck("wd");
        n = 0;
        while (FIB_IEA === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        checkOutput("wd_wait_cycles", 64'(n), 64'd72);
        checkOutput("wd_timeout", 64'(TIMEOUT), 64'd1);
        checkOutput("wd_iea", 64'(FIB_IEA), 64'd0);
        checkOutput("wd_done", 64'(DONE), 64'd0);
        checkOutput("wd_busy", 64'(BUSY), 64'd1);
        stubUnit = 1'b0;
        measureFlush("wd_flush");
        applyStimulus(2, 6'd1, 32'd1, 1);
        waitDrain("wd_retry");
        checkOutput("wd_timeout_sticky", 64'(TIMEOUT), 64'd1);

        // Reset in the middle of WAIT
        $display("[TB] reset mid-wait");
        applyStimulus(1, 6'd20, 32'd0, 0);
        waitAck("mid");
        repeat (3) tick();
        checkOutput("mid_iea_before", 64'(FIB_IEA), 64'd1);
        RST = 1'b1;
        tick();
        checkOutput("mid_iea_after", 64'(FIB_IEA), 64'd0);
        checkOutput("mid_timeout_cleared", 64'(TIMEOUT), 64'd0);
        checkOutput("mid_busy", 64'(BUSY), 64'd1);
        RST = 1'b0;
        measureFlush("mid_flush");
        applyStimulus(1, 6'd0, 32'd0, 1);
        waitDrain("mid_retry");

        checkOutput("ackq_empty", 64'(ackQ.size()), 64'd0);
        checkOutput("doneq_empty", 64'(doneQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("[TB] FAIL global_timeout: got expired expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
